fetch_unit: RTL and testbench

Instruction-fetch front end for the 8-bit, 19-bit-instruction pipeline. It owns the 12-bit program counter, drives the asynchronous-read instruction memory, and buffers fetched words in a small prefetch queue. The queue feeds the decode/datapath stage over a valid/ready handshake. Redirects (jump, taken branch, return) from the execute side flush the queue and restart fetch at the new address.

---
 rtl/fetch_unit.sv | 196 +++++++++++++++++++
 tb/tb_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Instruction-fetch front end for the 8-bit / 19-bit-instruction pipeline.
// Owns the program counter, drives the asynchronous-read instruction memory
// and buffers fetched words in a small prefetch queue. The queue head feeds
// decode over a valid/ready handshake. A redirect from execute flushes the
// queue and restarts fetch at the new address; the first target word is
// presented two cycles later (one bubble).
//
// Build option:
//   FETCH_PREFETCH2_EN  defined     -> two-entry prefetch queue (fetch runs
//                                      one word ahead of a stalled decode)
//                       not defined -> single IF/ID register
//
// Ports:
//   clk             clock, all state updates on the rising edge
//   rst             synchronous active-high reset
//   imem_addr       instruction-memory address (the PC register)
//   imem_data       instruction word at imem_addr, same cycle
//   redirect_valid  execute requests a PC change this cycle
//   redirect_pc     redirect target
//   id_ready        decode accepts the head entry this cycle
//   id_valid        head entry present
//   id_instruction  head instruction word
//   id_pc           address the head word was fetched from
//   id_pc_plus1     id_pc + 1 (wraps)
//   fetch_count     words pushed since reset, saturating
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int PC_W    = 12,
  parameter int INSTR_W = 19
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  input  logic               id_ready,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instruction,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus1,
  output logic [15:0]        fetch_count
);

`ifdef FETCH_PREFETCH2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [PC_W-1:0]    pc_reg,          pc_next;
  logic [PTR_W-1:0]   rd_ptr_reg,      rd_ptr_next;
  logic [PTR_W-1:0]   wr_ptr_reg,      wr_ptr_next;
  logic [CNT_W-1:0]   count_reg,       count_next;
  logic [15:0]        fetch_count_reg, fetch_count_next;

  // Queue storage, one {pc, instr} pair per entry.
  logic [PC_W-1:0]    entry_pc_reg    [DEPTH];
  logic [INSTR_W-1:0] entry_instr_reg [DEPTH];

  // Copy of the last valid head, shown while the queue is empty so the head
  // outputs do not jump to whatever stale word sits at slot 0 after a flush.
  logic [PC_W-1:0]    hold_pc_reg;
  logic [INSTR_W-1:0] hold_instr_reg;

  // -------------------------------------------------------------------------
  // Handshake / control
  // -------------------------------------------------------------------------
  logic               full;
  logic               pop;
  logic               push;
  logic [PC_W-1:0]    head_pc;
  logic [INSTR_W-1:0] head_instr;

  // Pointer advance modulo DEPTH; with a single entry the pointer is pinned.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (DEPTH == 1)
      return '0;
    else if (p == PTR_W'(DEPTH - 1))
      return '0;
    else
      return p + PTR_W'(1);
  endfunction

  assign id_valid = (count_reg != '0);
  assign full     = (count_reg == DEPTH_C);
  assign pop      = id_valid && id_ready;
  // A pop in the same cycle frees the slot, which gives full-rate throughput
  // even with a single entry. Redirect suppresses the push: the word at the
  // old PC is on the wrong path.
  assign push     = !redirect_valid && (!full || pop);

  always_comb begin
    pc_next          = pc_reg;
    rd_ptr_next      = rd_ptr_reg;
    wr_ptr_next      = wr_ptr_reg;
    count_next       = count_reg;
    fetch_count_next = fetch_count_reg;

    if (redirect_valid) begin
      // Flush everything; a concurrent pop was still taken by decode, but
      // the cleared count already accounts for it.
      pc_next     = redirect_pc;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        pc_next     = pc_reg + PC_W'(1);
        wr_ptr_next = ptr_inc(wr_ptr_reg);
      end
      if (pop) begin
        rd_ptr_next = ptr_inc(rd_ptr_reg);
      end
      unique case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end

    if (push && (fetch_count_reg != 16'hFFFF)) begin
      fetch_count_next = fetch_count_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg          <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      count_reg       <= '0;
      fetch_count_reg <= '0;
    end else begin
      pc_reg          <= pc_next;
      rd_ptr_reg      <= rd_ptr_next;
      wr_ptr_reg      <= wr_ptr_next;
      count_reg       <= count_next;
      fetch_count_reg <= fetch_count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Queue storage: each slot loads {PC, imem_data} when it is the push tail.
  // Slots are reset so the head reads 0 straight out of reset.
  // -------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic wr_en;
      assign wr_en = push && (wr_ptr_reg == PTR_W'(gi));

      always_ff @(posedge clk) begin
        if (rst) begin
          entry_pc_reg[gi]    <= '0;
          entry_instr_reg[gi] <= '0;
        end else if (wr_en) begin
          entry_pc_reg[gi]    <= pc_reg;
          entry_instr_reg[gi] <= imem_data;
        end
      end
    end
  endgenerate

  assign head_pc    = entry_pc_reg[rd_ptr_reg];
  assign head_instr = entry_instr_reg[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_pc_reg    <= '0;
      hold_instr_reg <= '0;
    end else if (id_valid) begin
      hold_pc_reg    <= head_pc;
      hold_instr_reg <= head_instr;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign imem_addr      = pc_reg;
  assign id_instruction = id_valid ? head_instr : hold_instr_reg;
  assign id_pc          = id_valid ? head_pc    : hold_pc_reg;
  assign id_pc_plus1    = id_pc + PC_W'(1);
  assign fetch_count    = fetch_count_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. The instruction memory is modelled as
// mem[a] = a + 19'h100. A scoreboard queue holds the PC sequence decode is
// expected to receive; it is reloaded whenever the bench starts a new stream
// (reset release, redirect). A negedge monitor pops it on every handshake
// and checks pc, instruction and pc+1. The main sequence adds directed
// checks on reset state, stall behaviour, bubbles and fetch_count.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

`ifdef FETCH_PREFETCH2_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] imem_addr;
  logic [18:0] imem_data;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic        id_ready;
  logic        id_valid;
  logic [18:0] id_instruction;
  logic [11:0] id_pc;
  logic [11:0] id_pc_plus1;
  logic [15:0] fetch_count;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q [$];
  logic [11:0] mon_pc;
  logic [15:0] fc_before;

  always #5 clk = ~clk;

  assign imem_data = 19'h100 + {7'd0, imem_addr};

  fetch_unit #(.PC_W(12), .INSTR_W(19)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_ready       (id_ready),
    .id_valid       (id_valid),
    .id_instruction (id_instruction),
    .id_pc          (id_pc),
    .id_pc_plus1    (id_pc_plus1),
    .fetch_count    (fetch_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_restart(input logic [11:0] start);
    exp_q.delete();
    for (int i = 0; i < 48; i++) exp_q.push_back(start + 12'(i));
  endtask

  // Handshake monitor: inputs change at posedge+1, so negedge sees stable
  // values for the cycle.
  always @(negedge clk) begin
    if (!rst && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_unexpected_pop observed_pc=%0h expected=none", id_pc);
      end else begin
        mon_pc = exp_q.pop_front();
        $display("pop pc=%03h instr=%05h pc_plus1=%03h", id_pc, id_instruction, id_pc_plus1);
        check("sb_id_pc", 32'(id_pc), 32'(mon_pc));
        check("sb_id_instruction", 32'(id_instruction), 32'(19'h100 + {7'd0, mon_pc}));
        check("sb_id_pc_plus1", 32'(id_pc_plus1), 32'(12'(mon_pc + 12'd1)));
      end
    end
  end

  initial begin
    rst            = 1'b1;
    id_ready       = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();

    // Reset state
    check("rst_id_valid", 32'(id_valid), 0);
    check("rst_imem_addr", 32'(imem_addr), 0);
    check("rst_fetch_count", 32'(fetch_count), 0);
    check("rst_id_instruction", 32'(id_instruction), 0);
    check("rst_id_pc", 32'(id_pc), 0);
    check("rst_id_pc_plus1", 32'(id_pc_plus1), 1);

    // Free run from address 0
    sb_restart(12'h000);
    rst = 1'b0;
    check("first_imem_addr", 32'(imem_addr), 0);
    check("first_id_valid", 32'(id_valid), 0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("run_fetch_count", 32'(fetch_count), 32'(k));
      check("run_id_valid", 32'(id_valid), 1);
      check("run_id_pc", 32'(id_pc), 32'(k - 1));
    end
    check("run_imem_addr", 32'(imem_addr), 4);

    // Stall five cycles with the head at pc 3
    id_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("stall_id_valid", 32'(id_valid), 1);
      check("stall_id_pc", 32'(id_pc), 3);
      check("stall_imem_addr", 32'(imem_addr), 32'(3 + DEPTH));
    end
    check("stall_fetch_count", 32'(fetch_count), 32'(3 + DEPTH));
    id_ready = 1'b1;
    tick();
    tick();
    tick();

    // Redirect to 0A0 with the queue filled, no pop
    id_ready = 1'b0;
    tick();
    fc_before      = fetch_count;
    redirect_valid = 1'b1;
    redirect_pc    = 12'h0A0;
    @(negedge clk);
    #1;
    sb_restart(12'h0A0);
    tick();
    redirect_valid = 1'b0;
    id_ready       = 1'b1;
    check("redir_bubble_valid", 32'(id_valid), 0);
    check("redir_imem_addr", 32'(imem_addr), 32'h0A0);
    check("redir_fetch_count", 32'(fetch_count), 32'(fc_before));
    tick();
    check("redir_target_valid", 32'(id_valid), 1);
    check("redir_target_pc", 32'(id_pc), 32'h0A0);
    check("redir_target_plus1", 32'(id_pc_plus1), 32'h0A1);
    tick();
    tick();
    tick();

    // Redirect to FFE in the same cycle decode pops the head
    check("redir_pop_head_valid", 32'(id_valid), 1);
    fc_before      = fetch_count;
    redirect_valid = 1'b1;
    redirect_pc    = 12'hFFE;
    @(negedge clk);
    #1;
    sb_restart(12'hFFE);
    tick();
    redirect_valid = 1'b0;
    check("redir_pop_valid", 32'(id_valid), 0);
    check("redir_pop_imem_addr", 32'(imem_addr), 32'hFFE);
    check("redir_pop_fetch_count", 32'(fetch_count), 32'(fc_before));
    tick();
    check("wrap_pc_ffe", 32'(id_pc), 32'hFFE);
    tick();
    check("wrap_pc_fff", 32'(id_pc), 32'hFFF);
    check("wrap_plus1_fff", 32'(id_pc_plus1), 32'h000);
    tick();
    check("wrap_pc_000", 32'(id_pc), 32'h000);
    tick();
    check("wrap_pc_001", 32'(id_pc), 32'h001);

    // Reset mid-stream with the queue full
    id_ready = 1'b0;
    tick();
    tick();
    check("prerst_full_valid", 32'(id_valid), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_id_valid", 32'(id_valid), 0);
    check("midrst_imem_addr", 32'(imem_addr), 0);
    check("midrst_fetch_count", 32'(fetch_count), 0);
    sb_restart(12'h000);
    id_ready = 1'b1;
    tick();
    check("midrst_first_valid", 32'(id_valid), 1);
    check("midrst_first_pc", 32'(id_pc), 0);
    for (int k = 0; k < 4; k++) tick();
    check("midrst_fetch_count_run", 32'(fetch_count), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
